bit_capture_in: RTL and testbench

//  Serial-to-parallel receiver; the input-side counterpart of the toggle-strobed LED bit shifter.

---
 rtl/bit_capture_in_if.sv | 27 ++
 rtl/bit_capture_in.sv | 114 +++++++++++
 tb/tb_bit_capture_in.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/bit_capture_in_if.sv
// Bus-side signal bundle for bit_capture_in: serial receive inputs plus the FIFO read port.
interface bit_capture_in_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              en;
  logic              sync;
  logic              data_in;
  logic              rd_en;
  logic              ovf_clr;
  logic [DATA_W-1:0] rd_data;
  logic              dma;
  logic              overflow;
  logic [LVL_W-1:0]  level;

  modport master (
    output en, sync, data_in, rd_en, ovf_clr,
    input  rd_data, dma, overflow, level
  );

  modport slave (
    input  en, sync, data_in, rd_en, ovf_clr,
    output rd_data, dma, overflow, level
  );
endinterface

// File: rtl/bit_capture_in.sv
// Toggle-strobed serial receiver: assembles MSB-first words, one bit per sync level change,
// and queues them in a small first-word-fall-through FIFO.
module bit_capture_in #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clock,
  input  logic           reset,
  bit_capture_in_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, ARM, RECV} state_t;

  state_t              state, state_next;
  logic                sync_q;
  logic                tog;
  logic [CNT_W-1:0]    bit_count, bit_count_next;
  // Only the first DATA_W-1 bits need storage; the last bit goes straight into the word.
  logic [DATA_W-2:0]   shreg, shreg_next;
  logic [DATA_W-1:0]   word;
  logic                push;

  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [LVL_W-1:0]    level, level_next;
  logic                full, empty, push_ok, pop_ok;
  logic                dma, overflow;

  assign tog  = (bus.sync != sync_q);
  assign word = {shreg, bus.data_in};

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      sync_q    <= 1'b0;
      bit_count <= '0;
      shreg     <= '0;
    end else begin
      state     <= state_next;
      sync_q    <= bus.sync;
      bit_count <= bit_count_next;
      shreg     <= shreg_next;
    end
  end

  always_comb begin
    state_next     = state;
    bit_count_next = bit_count;
    shreg_next     = shreg;
    push           = 1'b0;
    if (!bus.en) begin
      state_next     = IDLE;
      bit_count_next = '0;
      shreg_next     = '0;
    end else begin
      case (state)
        IDLE: state_next = ARM;
        ARM: begin
          bit_count_next = '0;
          shreg_next     = '0;
          state_next     = RECV;
        end
        RECV: begin
          if (tog) begin
            shreg_next = word[DATA_W-2:0];
            if (bit_count == CNT_W'(DATA_W - 1)) begin
              push           = 1'b1;
              bit_count_next = '0;
            end else begin
              bit_count_next = bit_count + CNT_W'(1);
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(FIFO_DEPTH));
  assign pop_ok  = bus.rd_en && !empty;
  // A pop on the same edge frees the slot, so a push onto a full FIFO still lands.
  assign push_ok = push && (!full || pop_ok);
  assign level_next = level + LVL_W'(push_ok) - LVL_W'(pop_ok);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      dma      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_next;
      dma   <= (level_next != '0);
      if (push && full && !bus.rd_en) overflow <= 1'b1;
      else if (bus.ovf_clr)           overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= word;
  end

  assign bus.rd_data  = empty ? '0 : mem[rd_ptr];
  assign bus.dma      = dma;
  assign bus.overflow = overflow;
  assign bus.level    = level;
endmodule

// File: tb/tb_bit_capture_in.sv
// Directed bench for bit_capture_in: expected words are queued at send time and a
// negedge monitor checks rd_data on every accepted read.
module tb_bit_capture_in;
  logic clock;
  logic reset;

  bit_capture_in_if #(.DATA_W(8), .FIFO_DEPTH(4)) bus ();

  bit_capture_in #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [7:0] sb [$];
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("check %s = %0h", name, act);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.data_in = b;
    bus.sync    = ~bus.sync;
    repeat (4) tick();
  endtask

  task automatic send_byte(input logic [7:0] v, input bit kept);
    if (kept) sb.push_back(v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic read1();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && bus.dma; i++) read1();
  endtask

  // Monitor: each accepted pop is checked against the oldest expected word.
  always @(negedge clock) begin
    if (!reset && bus.rd_en && bus.dma) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_data_unexpected actual=%0h required=none", bus.rd_data);
      end else begin
        chk("rd_data", int'(bus.rd_data), int'(sb.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] v;
    bus.en = 1'b0; bus.sync = 1'b0; bus.data_in = 1'b0;
    bus.rd_en = 1'b0; bus.ovf_clr = 1'b0;
    reset = 1'b1;
    tick(); tick();
    chk("rst_level", int'(bus.level), 0);
    chk("rst_dma", int'(bus.dma), 0);
    chk("rst_overflow", int'(bus.overflow), 0);
    chk("rst_rd_data", int'(bus.rd_data), 0);
    reset = 1'b0;
    tick();

    // 1: single word, one-clock latency after the 8th toggle
    bus.en = 1'b1;
    tick(); tick();
    v = 8'hA5;
    sb.push_back(v);
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    bus.data_in = v[0];
    bus.sync    = ~bus.sync;
    chk("t1_dma_before", int'(bus.dma), 0);
    tick();
    chk("t1_dma", int'(bus.dma), 1);
    chk("t1_level", int'(bus.level), 1);
    chk("t1_rd_data", int'(bus.rd_data), 8'hA5);
    repeat (3) tick();
    read1();
    chk("t1_dma_after", int'(bus.dma), 0);
    chk("t1_level_after", int'(bus.level), 0);
    chk("t1_rd_data_empty", int'(bus.rd_data), 0);

    // 2: overflow on the fifth word, sticky until cleared
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    chk("t2_overflow_before", int'(bus.overflow), 0);
    send_byte(8'h55, 1'b0);
    chk("t2_level", int'(bus.level), 4);
    chk("t2_overflow", int'(bus.overflow), 1);
    drain();
    chk("t2_level_drained", int'(bus.level), 0);
    chk("t2_overflow_sticky", int'(bus.overflow), 1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("t2_overflow_clr", int'(bus.overflow), 0);

    // 3: partial word discarded by en=0
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    bus.en = 1'b0;
    tick(); tick();
    bus.en = 1'b1;
    tick(); tick();
    send_byte(8'h3C, 1'b1);
    chk("t3_level", int'(bus.level), 1);
    drain();
    chk("t3_level_drained", int'(bus.level), 0);

    // 4: toggles in IDLE and ARM are not counted
    bus.en = 1'b0;
    bus.sync = 1'b1;
    repeat (3) tick();
    bus.en = 1'b1;
    bus.sync = ~bus.sync;
    tick();
    bus.sync = ~bus.sync;
    tick();
    send_byte(8'hFF, 1'b1);
    chk("t4_level", int'(bus.level), 1);
    chk("t4_rd_data", int'(bus.rd_data), 8'hFF);
    drain();

    // 5: push and pop on the same edge while full
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    chk("t5_level_full", int'(bus.level), 4);
    v = 8'h77;
    sb.push_back(v);
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    bus.data_in = v[0];
    bus.sync    = ~bus.sync;
    bus.rd_en   = 1'b1;
    tick();
    bus.rd_en   = 1'b0;
    chk("t5_level", int'(bus.level), 4);
    chk("t5_overflow", int'(bus.overflow), 0);
    drain();
    chk("t5_sb_empty", sb.size(), 0);

    // 6: reset mid-word with data queued
    send_byte(8'h10, 1'b1);
    send_byte(8'h20, 1'b1);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    chk("t6_level_pre", int'(bus.level), 2);
    reset = 1'b1;
    tick();
    chk("t6_level", int'(bus.level), 0);
    chk("t6_dma", int'(bus.dma), 0);
    chk("t6_overflow", int'(bus.overflow), 0);
    chk("t6_rd_data", int'(bus.rd_data), 0);
    sb.delete();
    reset = 1'b0;
    tick(); tick();
    send_byte(8'h81, 1'b1);
    chk("t6_level_new", int'(bus.level), 1);
    drain();
    read1();
    chk("t6_level_empty_rd", int'(bus.level), 0);
    chk("t6_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
